// File: rtl/led_matrix_pkg.sv
// ---------------------------------------------------------------------------
// led_matrix_pkg
// Shared definitions for the 8x8 LED matrix row-scan controller.
//   ROWS_DEF / COLS_DEF : default panel geometry
//   row_idx_t           : row index type for the default geometry
//   col_word_t          : one row of pixel bits for the default geometry
//   scan_state_t        : scan FSM states (BLANK, DISPLAY)
// ---------------------------------------------------------------------------
package led_matrix_pkg;

    localparam int ROWS_DEF = 8;
    localparam int COLS_DEF = 8;

    typedef logic [$clog2(ROWS_DEF)-1:0] row_idx_t;
    typedef logic [COLS_DEF-1:0]         col_word_t;

    typedef enum logic {
        BLANK   = 1'b0,
        DISPLAY = 1'b1
    } scan_state_t;

endpackage

// File: rtl/led_frame_bank.sv
// ---------------------------------------------------------------------------
// led_frame_bank
// Two-bank ROWS x COLS frame store. One bank is shown (front), the other is
// written by user logic (back). A swap pulse exchanges the roles.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears both banks)
//   wr_en       : write wr_data into back-bank row wr_row
//   wr_row      : row index; indices >= ROWS match no row and are dropped
//   wr_data     : row pixel bits
//   swap        : toggle the front pointer at this edge
//   rd_row      : front-bank row to read
//   rd_data     : combinational front-bank read data
// ---------------------------------------------------------------------------
import led_matrix_pkg::*;

module led_frame_bank #(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data
);

    localparam int RW = $clog2(ROWS);

    logic            front_sel;
    logic [COLS-1:0] bank0 [ROWS];
    logic [COLS-1:0] bank1 [ROWS];

    // Writes use the pointer value from before this edge, so a write that
    // coincides with a swap lands in the bank that becomes the new front.
    // Each row decodes its own index, so out-of-range indices hit nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            front_sel <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                bank0[r] <= '0;
                bank1[r] <= '0;
            end
        end else begin
            if (swap) begin
                front_sel <= ~front_sel;
            end
            for (int r = 0; r < ROWS; r++) begin
                if (wr_en && (wr_row == RW'(r))) begin
                    if (front_sel) begin
                        bank0[r] <= wr_data;
                    end else begin
                        bank1[r] <= wr_data;
                    end
                end
            end
        end
    end

    assign rd_data = front_sel ? bank1[rd_row] : bank0[rd_row];

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// led_matrix_scan_ctrl
// Row-scan sequencer for the 8x8 Pmod Matrix2 panel. Each row gets a
// BLANK_CYCLES blanking gap followed by TICK_DIV cycles of display. The
// displayed image comes from the front bank of a double-buffered frame
// store; the back bank is swapped in only at a frame boundary.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   wr_en/wr_row/wr_data : back-bank row write
//   swap_req     : swap request, held until swap_ack
//   brightness   : 3-bit duty level (only with LED_MATRIX_DIM_EN)
//   swap_ack     : one-cycle pulse, coincident with the frame start after a swap
//   frame_start  : one-cycle pulse in the first cycle of each frame
//   row_sel      : one-hot row drive, zero while blanking
//   col_data     : column data, zero while blanking
// Optional feature macro: LED_MATRIX_DIM_EN (PWM dimming inside DISPLAY).
// ---------------------------------------------------------------------------
import led_matrix_pkg::*;

module led_matrix_scan_ctrl #(
    parameter int ROWS         = ROWS_DEF,
    parameter int COLS         = COLS_DEF,
    parameter int TICK_DIV     = 300,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap_req,
`ifdef LED_MATRIX_DIM_EN
    input  logic [2:0]              brightness,
`endif
    output logic                    swap_ack,
    output logic                    frame_start,
    output logic [ROWS-1:0]         row_sel,
    output logic [COLS-1:0]         col_data
);

    localparam int RW      = $clog2(ROWS);
    localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    scan_state_t     state, next_state;
    logic [RW-1:0]   row, next_row;
    logic [CW-1:0]   cnt, next_cnt;
    logic            run;
    logic            swap_pend;
    logic            swap_now;
    logic            next_frame_start;
    logic [ROWS-1:0] next_row_sel;
    logic [COLS-1:0] next_col;
    logic [COLS-1:0] bank_data;

`ifdef LED_MATRIX_DIM_EN
    localparam int LW = $clog2(TICK_DIV) + 4;
    logic [LW-1:0] lit_lim, next_lit_lim, lit_prod;
`endif

    led_frame_bank #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .swap    (swap_now),
        .rd_row  (next_row),
        .rd_data (bank_data)
    );

    // Next-state and next-output decode. Outputs are computed from the
    // next state so that, once registered, they line up exactly with the
    // state they describe. Until the first edge out of reset ('run' low)
    // the scan position is held at the frame origin, which makes the first
    // cycle after release a frame start. A swap request is remembered in
    // swap_pend so one sampled in the ack cycle is still served next frame.
    always_comb begin
        next_state       = state;
        next_row         = row;
        next_cnt         = cnt + CW'(1);
        swap_now         = 1'b0;
        next_row_sel     = '0;
        next_col         = '0;
`ifdef LED_MATRIX_DIM_EN
        next_lit_lim     = lit_lim;
        lit_prod         = '0;
`endif
        if (!run) begin
            next_state = BLANK;
            next_row   = '0;
            next_cnt   = '0;
        end else begin
            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        next_state = DISPLAY;
                        next_cnt   = '0;
                    end
                end
                DISPLAY: begin
                    if (cnt == TICK_LAST) begin
                        next_state = BLANK;
                        next_cnt   = '0;
                        next_row   = (row == ROW_LAST) ? '0 : row + RW'(1);
                        swap_now   = (row == ROW_LAST) && (swap_req || swap_pend);
                    end
                end
                default: begin
                    next_state = BLANK;
                    next_cnt   = '0;
                end
            endcase
        end
        next_frame_start = (next_state == BLANK) && (next_row == '0) && (next_cnt == '0);
`ifdef LED_MATRIX_DIM_EN
        if ((state == BLANK) && (next_state == DISPLAY)) begin
            lit_prod     = (LW'(brightness) + LW'(1)) * LW'(TICK_DIV);
            next_lit_lim = lit_prod >> 3;
        end
`endif
        if (next_state == DISPLAY) begin
            next_row_sel = ROWS'(1) << next_row;
`ifdef LED_MATRIX_DIM_EN
            if (int'(next_cnt) < int'(next_lit_lim)) begin
                next_col = bank_data;
            end
`else
            next_col = bank_data;
`endif
        end
    end

    // State and output registers; reset aborts any frame or handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BLANK;
            row         <= '0;
            cnt         <= '0;
            run         <= 1'b0;
            swap_pend   <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            row_sel     <= '0;
            col_data    <= '0;
`ifdef LED_MATRIX_DIM_EN
            lit_lim     <= '0;
`endif
        end else begin
            state       <= next_state;
            row         <= next_row;
            cnt         <= next_cnt;
            run         <= 1'b1;
            swap_pend   <= swap_now ? 1'b0 : (swap_pend | swap_req);
            swap_ack    <= swap_now;
            frame_start <= next_frame_start;
            row_sel     <= next_row_sel;
            col_data    <= next_col;
`ifdef LED_MATRIX_DIM_EN
            lit_lim     <= next_lit_lim;
`endif
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_matrix_scan_ctrl
// Directed bench for led_matrix_scan_ctrl with TICK_DIV=4, BLANK_CYCLES=2
// (row period 6, frame 48). Cycle 0 is the first cycle after the first
// clock edge with rst_n high. Outputs are sampled 2 time units after each
// rising edge; inputs set at that point apply during the same cycle.
// ---------------------------------------------------------------------------
module tb_led_matrix_scan_ctrl;

    localparam int ROWS         = 8;
    localparam int COLS         = 8;
    localparam int TICK_DIV     = 4;
    localparam int BLANK_CYCLES = 2;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic [2:0]      wr_row;
    logic [COLS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;
    logic            frame_start;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_data;
`ifdef LED_MATRIX_DIM_EN
    logic [2:0]      brightness;
`endif

    int total;
    int bad;
    int cyc;

    led_matrix_scan_ctrl #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
`ifdef LED_MATRIX_DIM_EN
        .brightness  (brightness),
`endif
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .row_sel     (row_sel),
        .col_data    (col_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 2 units after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) next_cycle();
    endtask

    task automatic apply_stimulus(input logic we, input logic [2:0] r,
                                  input logic [7:0] d, input logic req);
        wr_en    = we;
        wr_row   = r;
        wr_data  = d;
        swap_req = req;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all(input logic [7:0] rs, input logic [7:0] cd,
                             input logic fs, input logic ack);
        check_output("row_sel", 32'(row_sel), 32'(rs));
        check_output("col_data", 32'(col_data), 32'(cd));
        check_output("frame_start", 32'(frame_start), 32'(fs));
        check_output("swap_ack", 32'(swap_ack), 32'(ack));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = -100;
        rst_n = 1'b0;
`ifdef LED_MATRIX_DIM_EN
        brightness = 3'd7;
`endif
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check_all(8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc   = -1;
        next_cycle();

        // Frame 0: empty banks, basic scan timing
        check_all(8'h00, 8'h00, 1'b1, 1'b0);
        goto_cycle(1);  check_all(8'h00, 8'h00, 1'b0, 1'b0);
        goto_cycle(2);  check_all(8'h01, 8'h00, 1'b0, 1'b0);
        goto_cycle(5);  check_all(8'h01, 8'h00, 1'b0, 1'b0);
        goto_cycle(6);  check_all(8'h00, 8'h00, 1'b0, 1'b0);
        goto_cycle(8);  check_all(8'h02, 8'h00, 1'b0, 1'b0);
        goto_cycle(10);
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1);
        goto_cycle(11); check_all(8'h02, 8'h00, 1'b0, 1'b0);

        // Fill the back bank with A5 while the request is held
        for (int i = 0; i < 8; i++) begin
            goto_cycle(12 + i);
            apply_stimulus(1'b1, 3'(i), 8'hA5, 1'b1);
        end
        goto_cycle(20);
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1);
        check_all(8'h08, 8'h00, 1'b0, 1'b0);
        goto_cycle(47); check_all(8'h80, 8'h00, 1'b0, 1'b0);

        // Frame 1: swapped in, request kept 2 extra cycles
        goto_cycle(48); check_all(8'h00, 8'h00, 1'b1, 1'b1);
        goto_cycle(49); check_all(8'h00, 8'h00, 1'b0, 1'b0);
        goto_cycle(50);
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0);
        check_all(8'h01, 8'hA5, 1'b0, 1'b0);
        goto_cycle(53); check_all(8'h01, 8'hA5, 1'b0, 1'b0);
        goto_cycle(54); check_all(8'h00, 8'h00, 1'b0, 1'b0);
        goto_cycle(60);
        apply_stimulus(1'b1, 3'd3, 8'hFF, 1'b0);
        goto_cycle(61);
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0);
        goto_cycle(68); check_all(8'h08, 8'hA5, 1'b0, 1'b0);
        goto_cycle(95);
        check_all(8'h80, 8'hA5, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'd0, 8'h3C, 1'b0);

        // Frame 2: second swap, write on the swap edge visible
        goto_cycle(96);
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0);
        check_all(8'h00, 8'h00, 1'b1, 1'b1);
        goto_cycle(97);  check_all(8'h00, 8'h00, 1'b0, 1'b0);
        goto_cycle(98);  check_all(8'h01, 8'h3C, 1'b0, 1'b0);
        goto_cycle(104); check_all(8'h02, 8'h00, 1'b0, 1'b0);
        goto_cycle(116); check_all(8'h08, 8'hFF, 1'b0, 1'b0);
        goto_cycle(143); check_all(8'h80, 8'h00, 1'b0, 1'b0);

        // Frame 3: no swap pending, image retained
        goto_cycle(144); check_all(8'h00, 8'h00, 1'b1, 1'b0);
        goto_cycle(146); check_all(8'h01, 8'h3C, 1'b0, 1'b0);
        goto_cycle(150);
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1);

        // Reset in mid-frame with a swap pending
        goto_cycle(177);
        check_all(8'h20, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0);
        next_cycle();
        check_all(8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc   = -1;
        next_cycle();
        check_all(8'h00, 8'h00, 1'b1, 1'b0);
        goto_cycle(2);  check_all(8'h01, 8'h00, 1'b0, 1'b0);
        goto_cycle(48); check_all(8'h00, 8'h00, 1'b1, 1'b0);
        goto_cycle(50); check_all(8'h01, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
